// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard transmitter.
// PS2_TX_ERR_INJECT_EN widens FIFO entries with a parity-corrupt flag.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_GAP
  } ps2_state_e;

`ifdef PS2_TX_ERR_INJECT_EN
  typedef struct packed {
    logic       err;
    logic [7:0] code;
  } fifo_entry_t;
`else
  typedef struct packed {
    logic [7:0] code;
  } fifo_entry_t;
`endif

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit for full/empty.
// A push while full is accepted when a pop happens in the same cycle.
module ps2_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard device model: queues scan-code bytes and sends them as
// device-to-host frames, backing off when the host inhibits the clock.
// Build option PS2_TX_ERR_INJECT_EN adds err_i to force a bad parity bit.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int FREQ_HZ    = 2000000,
  parameter int PS2_CLK_HZ = 12500,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] code_i,
`ifdef PS2_TX_ERR_INJECT_EN
  input  logic       err_i,
`endif
  input  logic       strobe_i,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int HALF = FREQ_HZ / (2 * PS2_CLK_HZ);
  localparam int CW   = $clog2(2 * HALF + 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * HALF - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  // Handshake: strobe_i is a one-cycle push with no ready; a push into a
  // full FIFO (without a same-cycle pop) is dropped and flagged on overflow_o.

  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        head_parity;

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          data_q, data_d;
  logic          clk_q;
  logic          busy_q;
  logic          overflow_q;

  always_comb begin
    push_entry      = '0;
    push_entry.code = code_i;
`ifdef PS2_TX_ERR_INJECT_EN
    push_entry.err  = err_i;
`endif
  end

`ifdef PS2_TX_ERR_INJECT_EN
  assign head_parity = odd_parity(head.code) ^ head.err;
`else
  assign head_parity = odd_parity(head.code);
`endif

  ps2_tx_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset_i),
    .push  (strobe_i),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The shift register holds {stop, parity, data}; the start bit is driven
  // directly when leaving IDLE and each rising edge shifts out the next bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        data_d = 1'b1;
        if (!fifo_empty && ps2_clk_i) begin
          state_d   = ST_SETUP;
          bit_cnt_d = '0;
          data_d    = 1'b0;
          shreg_d   = {1'b1, head_parity, head.code};
        end
      end
      ST_SETUP: begin
        if (cnt_q == HALF_END) begin
          state_d = ST_CLK_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (cnt_q == HALF_END) begin
          state_d = ST_CLK_HI;
          cnt_d   = '0;
          data_d  = shreg_q[0];
          shreg_d = {1'b1, shreg_q[9:1]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CLK_HI: begin
        // Host pulling the clock low aborts the frame, except on the stop bit.
        if (bit_cnt_q != LAST_BIT && !ps2_clk_i) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          data_d  = 1'b1;
        end else if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            pop     = 1'b1;
            state_d = ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = ST_CLK_LO;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        data_d = 1'b1;
        if (!ps2_clk_i) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        data_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '1;
      data_q     <= 1'b1;
      clk_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      clk_q      <= (state_d != ST_CLK_LO);
      busy_q     <= (state_q != ST_IDLE) | ~fifo_empty;
      overflow_q <= strobe_i & fifo_full & ~pop;
    end
  end

  assign ps2_clk_o  = clk_q;
  assign ps2_data_o = data_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: a line monitor rebuilds frames at each
// falling PS/2 clock edge and matches them against hand-computed frames.
module tb_ps2_kbd_tx;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] code_i;
  logic       strobe_i;
  logic       host_clk;
  logic       ps2_clk_i;
  logic       ps2_clk_o;
  logic       ps2_data_o;
  logic       busy_o;
  logic       overflow_o;
`ifdef PS2_TX_ERR_INJECT_EN
  logic       err_r;
`endif

  // Wired-AND of device and host clock drives.
  assign ps2_clk_i = ps2_clk_o & host_clk;

  ps2_kbd_tx dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .code_i     (code_i),
`ifdef PS2_TX_ERR_INJECT_EN
    .err_i      (err_r),
`endif
    .strobe_i   (strobe_i),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_data_o (ps2_data_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / line monitor ----------------
  logic [10:0] exp_q[$];
  int          cyc         = 0;
  int          last_fall   = 0;
  int          nbits       = 0;
  int          rx_count    = 0;
  int          falls_total = 0;
  int          rises_total = 0;
  logic        prev_clk    = 1'b1;
  logic [10:0] rx_bits     = '0;
  logic [31:0] exp_frame;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_clk === 1'b1 && ps2_clk_o === 1'b0) begin
      falls_total++;
      // A long silence means the previous partial frame was abandoned.
      if (nbits != 0 && (cyc - last_fall) > 2 * HALF + 40) nbits = 0;
      if (nbits != 0) check_eq("fall_spacing", cyc - last_fall, 2 * HALF);
      rx_bits[nbits] = ps2_data_o;
      nbits++;
      last_fall = cyc;
      if (nbits == 11) begin
        if (exp_q.size() != 0) exp_frame = 32'(exp_q.pop_front());
        else exp_frame = 'x;
        check_eq("frame", 32'(rx_bits), exp_frame);
        nbits = 0;
        rx_count++;
      end
    end
    if (prev_clk === 1'b0 && ps2_clk_o === 1'b1) rises_total++;
    prev_clk = ps2_clk_o;
  end

  // ---------------- driver tasks ----------------
  logic busy_was_low;

  task automatic tick();
    @(posedge clk);
    #2;
    if (busy_o !== 1'b1) busy_was_low = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    code_i   = b;
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
  endtask

  task automatic wait_data_low(input int budget, output int n);
    n = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ps2_data_o === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_clk_low(input int budget, output int n);
    n = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ps2_clk_o === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_busy_low(input int budget, output int n);
    n = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (busy_o === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_fall_after(input int f0, input int budget, output int n);
    n = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (falls_total != f0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rx_count >= target) break;
      tick();
    end
  endtask

  task automatic wait_rises(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rises_total >= target) break;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  int n;
  int base;
  int f0;
  int r0;

  initial begin
    reset_i      = 1'b1;
    strobe_i     = 1'b0;
    code_i       = '0;
    host_clk     = 1'b1;
    busy_was_low = 1'b0;
`ifdef PS2_TX_ERR_INJECT_EN
    err_r        = 1'b0;
`endif
    repeat (3) tick();
    check_eq("rst_clk_o", ps2_clk_o, 1);
    check_eq("rst_data_o", ps2_data_o, 1);
    check_eq("rst_busy_o", busy_o, 0);
    check_eq("rst_overflow_o", overflow_o, 0);
    reset_i = 1'b0;
    tick();

    // Single byte 0x1C: frame bits 0,0,0,1,1,1,0,0,0,0,1.
    base = rx_count;
    exp_q.push_back(11'h438);
    push(8'h1C);
    wait_data_low(10, n);
    check_eq("t1_start_latency", n, 1);
    wait_clk_low(500, n);
    check_eq("t1_first_fall", n, HALF);
    wait_rx(base + 1, 3000);
    check_eq("t1_rx_count", rx_count, base + 1);
    wait_busy_low(1000, n);
    check_eq("t1_busy_idle", busy_o, 0);

    // Back-to-back 0xF0, 0x1C: parity 1 then 0, busy held through both.
    base = rx_count;
    exp_q.push_back(11'h7E0);
    exp_q.push_back(11'h438);
    push(8'hF0);
    push(8'h1C);
    busy_was_low = 1'b0;
    wait_rx(base + 1, 3000);
    f0 = falls_total;
    wait_fall_after(f0, 600, n);
    check_eq("t2_interframe_fall_gap", n, 5 * HALF + 1);
    wait_rx(base + 2, 3000);
    check_eq("t2_rx_count", rx_count, base + 2);
    check_eq("t2_busy_held", busy_was_low, 0);
    wait_busy_low(1000, n);
    check_eq("t2_busy_fall_delay", n, 4 * HALF + 1);

    // Five pushes into a 4-deep FIFO: the fifth is dropped.
    base = rx_count;
    exp_q.push_back(11'h402);
    exp_q.push_back(11'h606);
    exp_q.push_back(11'h40E);
    exp_q.push_back(11'h61E);
    push(8'h01);
    check_eq("t3_ovf_push1", overflow_o, 0);
    push(8'h03);
    push(8'h07);
    push(8'h0F);
    check_eq("t3_ovf_push4", overflow_o, 0);
    push(8'hFF);
    check_eq("t3_ovf_push5", overflow_o, 1);
    tick();
    check_eq("t3_ovf_pulse_end", overflow_o, 0);
    wait_rx(base + 4, 10000);
    wait_busy_low(2000, n);
    repeat (300) tick();
    check_eq("t3_rx_count", rx_count, base + 4);

    // Host inhibit during CLK_HI of bit 4 aborts; byte resent in full.
    base = rx_count;
    exp_q.push_back(11'h494);
    push(8'h4A);
    r0 = rises_total;
    wait_rises(r0 + 5, 2000);
    check_eq("t4_reach_bit4", rises_total, r0 + 5);
    repeat (20) tick();
    check_eq("t4_data_before_abort", ps2_data_o, 0);
    f0 = falls_total;
    host_clk = 1'b0;
    tick();
    check_eq("t4_abort_data_released", ps2_data_o, 1);
    check_eq("t4_abort_clk_released", ps2_clk_o, 1);
    repeat (300) tick();
    check_eq("t4_quiet_while_inhibited", falls_total, f0);
    check_eq("t4_busy_while_inhibited", busy_o, 1);
    host_clk = 1'b1;
    wait_data_low(400, n);
    check_eq("t4_restart_latency", n, 2 * HALF + 1);
    wait_rx(base + 1, 3000);
    check_eq("t4_rx_count", rx_count, base + 1);
    wait_busy_low(1000, n);

    // Host inhibit in IDLE holds off the frame start.
    base = rx_count;
    exp_q.push_back(11'h452);
    host_clk = 1'b0;
    push(8'h29);
    f0 = falls_total;
    repeat (300) tick();
    check_eq("t5_no_clock_activity", falls_total, f0);
    check_eq("t5_data_idle", ps2_data_o, 1);
    check_eq("t5_busy_pending", busy_o, 1);
    host_clk = 1'b1;
    wait_data_low(5, n);
    check_eq("t5_start_after_release", n, 1);
    wait_rx(base + 1, 3000);
    check_eq("t5_rx_count", rx_count, base + 1);
    wait_busy_low(1000, n);

    // Reset mid-frame releases the lines and empties the FIFO.
    push(8'h33);
    push(8'h44);
    wait_clk_low(500, n);
    check_eq("t6_in_start_bit", ps2_data_o, 0);
    reset_i = 1'b1;
    tick();
    check_eq("t6_rst_clk_o", ps2_clk_o, 1);
    check_eq("t6_rst_data_o", ps2_data_o, 1);
    check_eq("t6_rst_busy_o", busy_o, 0);
    reset_i = 1'b0;
    f0 = falls_total;
    base = rx_count;
    repeat (2500) tick();
    check_eq("t6_fifo_flushed", falls_total, f0);
    check_eq("t6_busy_after", busy_o, 0);
    check_eq("t6_rx_count", rx_count, base);

`ifdef PS2_TX_ERR_INJECT_EN
    // Injected error flips the parity bit of 0x1C to 1.
    base = rx_count;
    exp_q.push_back(11'h638);
    err_r = 1'b1;
    push(8'h1C);
    err_r = 1'b0;
    wait_rx(base + 1, 3000);
    check_eq("t7_rx_count", rx_count, base + 1);
    wait_busy_low(1000, n);
`endif

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
